// File: rtl/vpd_pkg.sv
// Shared types and constants for the VPD capability access controller.
package vpd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StDone
    } state_t;

    localparam int unsigned VPD_DWORD_BYTES = 4;
    localparam int unsigned VPD_F_BIT       = 15;

endpackage

// File: rtl/vpd_access_controller_if.sv
// Config-space and byte-storage signals of the VPD access controller.
interface vpd_access_controller_if #(
    parameter int unsigned ADDR_WIDTH = 15
);
    logic                  cfg_addr_we;
    logic [15:0]           cfg_addr_wdata;
    logic                  cfg_data_we;
    logic [31:0]           cfg_data_wdata;
    logic [15:0]           cfg_addr_rdata;
    logic [31:0]           cfg_data_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;
    logic                  mem_ack;
    logic                  busy;
    logic                  err_timeout;

    // Controller side.
    modport slave (
        input  cfg_addr_we, cfg_addr_wdata, cfg_data_we, cfg_data_wdata, mem_rdata, mem_ack,
        output cfg_addr_rdata, cfg_data_rdata, mem_req, mem_we, mem_addr, mem_wdata,
        output busy, err_timeout
    );

    // Host / storage side.
    modport master (
        output cfg_addr_we, cfg_addr_wdata, cfg_data_we, cfg_data_wdata, mem_rdata, mem_ack,
        input  cfg_addr_rdata, cfg_data_rdata, mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, err_timeout
    );
endinterface

// File: rtl/vpd_access_controller.sv
// VPD capability register pair: turns an address write into a 4-byte storage transfer
// with per-byte handshake, little-endian byte packing and a per-byte ack timeout.
module vpd_access_controller
    import vpd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_WIDTH     = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vpd_access_controller_if.slave bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q;
    logic                  f_q;
    logic [14:0]           addr_q;
    logic [31:0]           data_q;
    logic                  err_q;
    logic                  busy_q;
    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] maddr_q;
    logic [7:0]            wdata_q;
    logic [1:0]            idx_q;
    logic [CntW-1:0]       cnt_q;

    logic                  addr_ok;
    logic [4:0]            bit_ofs;

    assign addr_ok = bus.cfg_addr_we && (bus.cfg_addr_wdata[1:0] == 2'b00);
    assign bit_ofs = {idx_q, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            f_q     <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Data is taken before the address so a same-cycle write uses it.
                    if (bus.cfg_data_we) data_q <= bus.cfg_data_wdata;
                    if (addr_ok) begin
                        f_q     <= bus.cfg_addr_wdata[VPD_F_BIT];
                        addr_q  <= bus.cfg_addr_wdata[VPD_F_BIT-1:0];
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    req_q   <= 1'b1;
                    we_q    <= f_q;
                    maddr_q <= ADDR_WIDTH'(addr_q) + ADDR_WIDTH'(idx_q);
                    wdata_q <= data_q[bit_ofs +: 8];
                    cnt_q   <= '0;
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (bus.mem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) data_q[bit_ofs +: 8] <= bus.mem_rdata;
                        if (idx_q == 2'(VPD_DWORD_BYTES - 1)) begin
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= StIssue;
                        end
                    end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        // Abort without completing: F keeps its in-progress value.
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    f_q     <= ~f_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cfg_addr_rdata = {f_q, addr_q};
    assign bus.cfg_data_rdata = data_q;
    assign bus.mem_req        = req_q;
    assign bus.mem_we         = we_q;
    assign bus.mem_addr       = maddr_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.busy           = busy_q;
    assign bus.err_timeout    = err_q;

endmodule

// File: tb/tb_vpd_access_controller.sv
// Bench for vpd_access_controller: table vectors, randomized transfers against a
// transaction-level model, and hand-written misaligned and mid-transfer reset sequences.
module tb_vpd_access_controller;

    localparam int unsigned TO = 8;
    localparam int unsigned AW = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vpd_access_controller_if #(.ADDR_WIDTH(AW)) bus ();

    vpd_access_controller #(
        .TIMEOUT_CYCLES(TO),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    // Transaction-level model of the visible registers.
    logic [31:0] m_data;
    logic        m_f;
    logic [14:0] m_addr;
    logic        m_err;
    int          dly[4];
    logic [7:0]  rb[4];

    typedef struct {
        logic [15:0] aw;
        logic [31:0] dw;
        bit          wd;
        logic [15:0] d;      // ack delay per byte, nibble i = byte i
        logic [31:0] r;      // storage read bytes, little-endian
        logic [31:0] e_data;
        logic [15:0] e_addr_rd;
        bit          e_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic junk();
        bus.cfg_addr_we    = 1'($urandom_range(0, 1));
        bus.cfg_addr_wdata = 16'($urandom) & 16'hFFFC;
        bus.cfg_data_we    = 1'($urandom_range(0, 1));
        bus.cfg_data_wdata = $urandom;
    endtask

    task automatic idle_inputs();
        bus.cfg_addr_we = 1'b0;
        bus.cfg_data_we = 1'b0;
        bus.mem_ack     = 1'b0;
    endtask

    // Runs one accepted transfer from a negedge in IDLE; uses dly[]/rb[] as the storage.
    task automatic do_xfer(input logic [15:0] aw, input logic [31:0] dw, input bit wd);
        int lat;
        int exp_lat;
        bit to;
        if (wd) m_data = dw;
        m_f    = aw[15];
        m_addr = aw[14:0];
        m_err  = 1'b0;
        exp_lat = 1;
        for (int i = 0; i < 4; i++) exp_lat += 2 + dly[i];
        bus.cfg_addr_we    = 1'b1;
        bus.cfg_addr_wdata = aw;
        bus.cfg_data_we    = wd;
        bus.cfg_data_wdata = dw;
        @(negedge clk);
        lat = 0;
        idle_inputs();
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("err_cleared", 32'(bus.err_timeout), 32'd0);
        to = 1'b0;
        for (int i = 0; i < 4 && !to; i++) begin
            check("req_gap", 32'(bus.mem_req), 32'd0);
            check("addr_rd_busy", 32'(bus.cfg_addr_rdata), 32'({m_f, m_addr}));
            junk();
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = 8'($urandom);
            @(negedge clk);
            lat++;
            bus.mem_ack = 1'b0;
            for (int w = 0; w < int'(TO); w++) begin
                check("req_high", 32'(bus.mem_req), 32'd1);
                check("mem_we", 32'(bus.mem_we), 32'(m_f));
                check("mem_addr", 32'(bus.mem_addr), (int'(m_addr) + i) % (1 << AW));
                if (m_f) check("mem_wdata", 32'(bus.mem_wdata), 32'(m_data[8*i +: 8]));
                junk();
                if (w == dly[i]) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rb[i];
                    if (!m_f) m_data[8*i +: 8] = rb[i];
                    @(negedge clk);
                    lat++;
                    bus.mem_ack = 1'b0;
                    break;
                end
                @(negedge clk);
                lat++;
                if (w == int'(TO) - 1) to = 1'b1;
            end
        end
        if (to) begin
            m_err = 1'b1;
            check("to_req_low", 32'(bus.mem_req), 32'd0);
        end else begin
            check("done_req_low", 32'(bus.mem_req), 32'd0);
            check("done_busy", 32'(bus.busy), 32'd1);
            junk();
            @(negedge clk);
            lat++;
            m_f = ~m_f;
            check("latency", 32'(lat), 32'(exp_lat));
        end
        idle_inputs();
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_addr_rd", 32'(bus.cfg_addr_rdata), 32'({m_f, m_addr}));
        check("end_data", bus.cfg_data_rdata, m_data);
        check("end_err", 32'(bus.err_timeout), 32'(m_err));
    endtask

    vec_t vecs[7];

    initial begin
        rst_n = 1'b0;
        bus.cfg_addr_wdata = '0;
        bus.cfg_data_wdata = '0;
        bus.mem_rdata      = '0;
        idle_inputs();
        m_data = '0; m_f = 1'b0; m_addr = '0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr_rd", 32'(bus.cfg_addr_rdata), 32'd0);
        check("rst_data", bus.cfg_data_rdata, 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{16'h0010, 32'h0, 1'b0, 16'h0000, 32'h44332211, 32'h44332211, 16'h8010, 1'b0};
        vecs[1] = '{16'h8020, 32'hA5B6C7D8, 1'b1, 16'h0000, 32'h0, 32'hA5B6C7D8, 16'h0020, 1'b0};
        vecs[2] = '{16'h7FFC, 32'h0, 1'b0, 16'h7021, 32'hDEADBEEF, 32'hDEADBEEF, 16'hFFFC, 1'b0};
        vecs[3] = '{16'hFFFC, 32'h0, 1'b0, 16'h3210, 32'h0, 32'hDEADBEEF, 16'h7FFC, 1'b0};
        vecs[4] = '{16'h0100, 32'h0, 1'b0, 16'h0080, 32'h77665544, 32'hDEADBE44, 16'h0100, 1'b1};
        vecs[5] = '{16'h8200, 32'h12345678, 1'b1, 16'h0008, 32'h0, 32'h12345678, 16'h8200, 1'b1};
        vecs[6] = '{16'h0004, 32'h0, 1'b0, 16'h0000, 32'hCAFEF00D, 32'hCAFEF00D, 16'h8004, 1'b0};
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) begin
                dly[i] = int'(vecs[v].d[4*i +: 4]);
                rb[i]  = vecs[v].r[8*i +: 8];
            end
            do_xfer(vecs[v].aw, vecs[v].dw, vecs[v].wd);
            check("vec_data", bus.cfg_data_rdata, vecs[v].e_data);
            check("vec_addr_rd", 32'(bus.cfg_addr_rdata), 32'(vecs[v].e_addr_rd));
            check("vec_err", 32'(bus.err_timeout), 32'(vecs[v].e_err));
        end

        // Misaligned address writes are dropped entirely.
        bus.cfg_addr_we    = 1'b1;
        bus.cfg_addr_wdata = 16'h0013;
        @(negedge clk);
        bus.cfg_addr_wdata = 16'h8002;
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            check("misal_req", 32'(bus.mem_req), 32'd0);
            check("misal_busy", 32'(bus.busy), 32'd0);
            check("misal_addr_rd", 32'(bus.cfg_addr_rdata), 32'h8004);
            @(negedge clk);
        end

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                dly[i] = ($urandom_range(0, 9) == 0) ? int'(TO) : int'($urandom_range(0, 3));
                rb[i]  = 8'($urandom);
            end
            do_xfer({1'($urandom_range(0, 1)), 13'($urandom), 2'b00}, $urandom,
                    bit'($urandom_range(0, 1)));
            @(negedge clk);
        end

        // Reset while byte 2 is waiting for its ack.
        bus.cfg_addr_we    = 1'b1;
        bus.cfg_addr_wdata = 16'h0040;
        @(negedge clk);
        idle_inputs();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 8'hA0 + 8'(b);
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        @(negedge clk);
        check("byte2_req", 32'(bus.mem_req), 32'd1);
        check("byte2_addr", 32'(bus.mem_addr), 32'h42);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_req", 32'(bus.mem_req), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_addr_rd", 32'(bus.cfg_addr_rdata), 32'd0);
        check("mrst_data", bus.cfg_data_rdata, 32'd0);
        check("mrst_err", 32'(bus.err_timeout), 32'd0);
        check("mrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("mrst_mem_we", 32'(bus.mem_we), 32'd0);
        check("mrst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_req", 32'(bus.mem_req), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
